// File: rtl/time_of_day_counter.sv
// 24 h hours:minutes:seconds counter driven by rising edges of an asynchronous tick wave, with set mode for manual adjust.
// Latency: tick_in rise before edge k -> time/sec_tick update after edge k+2; no backpressure, every qualified edge is counted.
module time_of_day_counter #(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       sec_tick,
    output logic       day_wrap
);

    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);

    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] fill_q;
    logic       armed_q, armed_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       sec_tick_q, sec_tick_d;
    logic       day_wrap_q, day_wrap_d;

    logic tick_pulse;
    logic sec_at_max, min_at_max, hour_at_max;

    assign tick_pulse  = armed_q & sync2_q & ~prev_q;
    assign sec_at_max  = (sec_q == SEC_LAST);
    assign min_at_max  = (min_q == MIN_LAST);
    assign hour_at_max = (hour_q == HOUR_LAST);

    // fill_q[1] marks sync2 as holding a genuine sample, so the reset value of
    // the chain can never arm the detector while tick_in is held high.
    assign armed_d = armed_q | (fill_q[1] & ~sync2_q);

    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        if (set_mode) begin
            sec_d = '0;
            if (inc_min) begin
                min_d = min_at_max ? '0 : min_q + 6'd1;
            end
            if (inc_hour) begin
                hour_d = hour_at_max ? '0 : hour_q + 5'd1;
            end
        end else if (tick_pulse) begin
            sec_tick_d = 1'b1;
            if (!sec_at_max) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = '0;
                if (!min_at_max) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = '0;
                    if (!hour_at_max) begin
                        hour_d = hour_q + 5'd1;
                    end else begin
                        hour_d     = '0;
                        day_wrap_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            fill_q     <= 2'b00;
            armed_q    <= 1'b0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            sync1_q    <= tick_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            fill_q     <= {fill_q[0], 1'b1};
            armed_q    <= armed_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign hours    = hour_q;
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;

endmodule
